// File: rtl/contact_pkg.sv
// Shared definitions for the contact beacon: prime table, FSM state encoding
// and a helper used to size the gap/pulse timer.
package contact_pkg;

  localparam int unsigned MAX_PRIMES = 16;

  localparam logic [7:0] PRIME_TABLE [MAX_PRIMES] = '{
    8'd2,  8'd3,  8'd5,  8'd7,  8'd11, 8'd13, 8'd17, 8'd19,
    8'd23, 8'd29, 8'd31, 8'd37, 8'd41, 8'd43, 8'd47, 8'd53
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE_HI,
    ST_PULSE_LO,
    ST_PRIME_GAP,
    ST_SEQ_GAP
  } state_e;

  function automatic int unsigned max_len(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/contact_timer.sv
// Loadable down-counter: a load strobe sets the count, which then decrements
// to zero and holds; zero_o flags the final cycle of a timed state.
module contact_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/contact_seq_gen.sv
// Prime-number pulse-train beacon: emits 2,3,5,... pulses per sequence with
// programmable gaps, start/abort control, one-shot or continuous operation.
module contact_seq_gen
  import contact_pkg::*;
#(
  parameter int unsigned NUM_PRIMES   = 16,
  parameter int unsigned PULSE_LEN    = 32'h007A1200,
  parameter int unsigned PULSE_GAP    = 32'h007A1200,
  parameter int unsigned PRIME_GAP    = 32'h00F42400,
  parameter int unsigned SEQ_GAP      = 32'h01E84800,
  parameter int unsigned CNT_WIDTH    = 32,
  parameter logic        CNT_SATURATE = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 continuous_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic                 pulse_out_o,
  output logic                 busy_o,
  output logic                 seq_done_o,
  output logic [7:0]           cur_prime_o,
  output logic [CNT_WIDTH-1:0] seq_cnt_o
);

  localparam int unsigned MAX_LEN = max_len(PULSE_LEN, PULSE_GAP, PRIME_GAP, SEQ_GAP);
  localparam int unsigned TIMER_W = $clog2(MAX_LEN) + 1;

  localparam logic [TIMER_W-1:0] PULSE_LEN_M1 = TIMER_W'(PULSE_LEN - 1);
  localparam logic [TIMER_W-1:0] PULSE_GAP_M1 = TIMER_W'(PULSE_GAP - 1);
  localparam logic [TIMER_W-1:0] PRIME_GAP_M1 = TIMER_W'(PRIME_GAP - 1);
  localparam logic [TIMER_W-1:0] SEQ_GAP_M1   = TIMER_W'(SEQ_GAP - 1);
  localparam logic [3:0]         LAST_PRIME   = 4'(NUM_PRIMES - 1);

  if (NUM_PRIMES == 0 || NUM_PRIMES > MAX_PRIMES) begin : g_bad_num_primes
    $error("contact_seq_gen: NUM_PRIMES must be within 1..16");
  end
  if (PULSE_LEN == 0 || PULSE_GAP == 0 || PRIME_GAP == 0 || SEQ_GAP == 0) begin : g_bad_len
    $error("contact_seq_gen: all pulse and gap lengths must be at least 1");
  end
  if (CNT_WIDTH == 0 || CNT_WIDTH > 32) begin : g_bad_cnt_width
    $error("contact_seq_gen: CNT_WIDTH must be within 1..32");
  end

  state_e               state_q, state_d;
  logic [3:0]           prime_idx_q, prime_idx_d;
  logic [7:0]           pulse_idx_q, pulse_idx_d;
  logic [CNT_WIDTH-1:0] seq_cnt_q, seq_cnt_d;
  logic                 pulse_out_q;
  logic                 tmr_load;
  logic [TIMER_W-1:0]   tmr_val;
  logic                 tmr_zero;
  logic                 seq_end;
  logic [7:0]           prime_val;

  assign prime_val = PRIME_TABLE[prime_idx_q];

  contact_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // abort outranks everything, including a timer expiring in the same cycle
  always_comb begin
    state_d     = state_q;
    prime_idx_d = prime_idx_q;
    pulse_idx_d = pulse_idx_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    seq_end     = 1'b0;
    if (abort_i) begin
      state_d     = ST_IDLE;
      prime_idx_d = '0;
      pulse_idx_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i && enable_i) begin
            state_d     = ST_PULSE_HI;
            prime_idx_d = '0;
            pulse_idx_d = '0;
            tmr_load    = 1'b1;
            tmr_val     = PULSE_LEN_M1;
          end
        end
        ST_PULSE_HI: begin
          if (tmr_zero) begin
            tmr_load = 1'b1;
            if (pulse_idx_q < (prime_val - 8'd1)) begin
              state_d     = ST_PULSE_LO;
              pulse_idx_d = pulse_idx_q + 8'd1;
              tmr_val     = PULSE_GAP_M1;
            end else if (prime_idx_q < LAST_PRIME) begin
              state_d = ST_PRIME_GAP;
              tmr_val = PRIME_GAP_M1;
            end else begin
              state_d = ST_SEQ_GAP;
              tmr_val = SEQ_GAP_M1;
            end
          end
        end
        ST_PULSE_LO: begin
          if (tmr_zero) begin
            state_d  = ST_PULSE_HI;
            tmr_load = 1'b1;
            tmr_val  = PULSE_LEN_M1;
          end
        end
        ST_PRIME_GAP: begin
          if (tmr_zero) begin
            state_d     = ST_PULSE_HI;
            prime_idx_d = prime_idx_q + 4'd1;
            pulse_idx_d = '0;
            tmr_load    = 1'b1;
            tmr_val     = PULSE_LEN_M1;
          end
        end
        ST_SEQ_GAP: begin
          if (tmr_zero) begin
            seq_end     = 1'b1;
            prime_idx_d = '0;
            pulse_idx_d = '0;
            if (continuous_i && enable_i) begin
              state_d  = ST_PULSE_HI;
              tmr_load = 1'b1;
              tmr_val  = PULSE_LEN_M1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d     = ST_IDLE;
          prime_idx_d = '0;
          pulse_idx_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    seq_cnt_d = seq_cnt_q;
    if (seq_end && !(CNT_SATURATE && (&seq_cnt_q))) begin
      seq_cnt_d = seq_cnt_q + CNT_WIDTH'(1);
    end
  end

  // pulse_out follows the next state so it is high on exactly the PULSE_HI cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      prime_idx_q <= '0;
      pulse_idx_q <= '0;
      seq_cnt_q   <= '0;
      pulse_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prime_idx_q <= prime_idx_d;
      pulse_idx_q <= pulse_idx_d;
      seq_cnt_q   <= seq_cnt_d;
      pulse_out_q <= (state_d == ST_PULSE_HI);
    end
  end

  assign pulse_out_o = pulse_out_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign seq_done_o  = seq_end;
  assign cur_prime_o = (state_q == ST_IDLE) ? 8'd0 : prime_val;
  assign seq_cnt_o   = seq_cnt_q;

endmodule
